// File: rtl/alu_6502_if.sv
// Request/response bundle between the CPU core and the 6502 ALU.
// Both directions use the same valid/ready rule: a transfer happens on a
// rising clock edge where valid and ready are both high; the sender keeps
// valid and its payload steady until that edge.
interface alu_6502_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             decimal;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_v;
  logic             flag_z;
  logic             flag_c;

  // requester side (CPU core)
  modport master (
    output in_valid, op, a, b, carry_in, decimal, out_ready,
    input  in_ready, out_valid, result, flag_n, flag_v, flag_z, flag_c
  );

  // ALU side
  modport slave (
    input  in_valid, op, a, b, carry_in, decimal, out_ready,
    output in_ready, out_valid, result, flag_n, flag_v, flag_z, flag_c
  );
endinterface

// File: rtl/alu_6502_core.sv
// Registered 6502-style ALU: one op in flight, binary ops answer one cycle
// after acceptance, BCD ADC/SBC take an extra nibble-adjust cycle.
module alu_6502_core #(
  parameter int WIDTH      = 8,
  parameter bit DECIMAL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_6502_if.slave   bus,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORA = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_ASL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADJ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             in_ready_o, out_valid_o;
  logic             accept, go_bcd;

  // binary datapath outputs for the operation being offered
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res_d, flag_src;
  logic             n_d, v_d, z_d, c_d;

  // operands and binary flags held across the adjust cycle
  logic [WIDTH-1:0] a_q, b_q;
  logic             c_q, sub_q, bin_n_q, bin_v_q;
  logic [WIDTH:0]   bcd_out;

  // registered outputs
  logic [WIDTH-1:0] res_q;
  logic             n_q, v_q, z_q, c_q_out;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign go_bcd = DECIMAL_EN && bus.decimal &&
                  ((bus.op == OP_ADC) || (bus.op == OP_SBC));

  // Per-nibble decimal correction, low nibble first. Addition adds 6 to
  // any digit that exceeded 9; subtraction removes 6 from any digit that
  // borrowed. Returns {final carry, adjusted value}.
  function automatic logic [WIDTH:0] bcd_adjust(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             cin,
    input logic             sub
  );
    logic [WIDTH-1:0] r;
    logic             cy;
    logic [4:0]       t;
    logic [3:0]       yn;
    r  = '0;
    cy = cin;
    for (int i = 0; i < WIDTH / 4; i++) begin
      yn = sub ? ~y[4*i +: 4] : y[4*i +: 4];
      t  = {1'b0, x[4*i +: 4]} + {1'b0, yn} + {4'b0, cy};
      if (sub) begin
        cy = t[4];
        r[4*i +: 4] = cy ? t[3:0] : (t[3:0] - 4'd6);
      end else if (t > 5'd9) begin
        t  = t + 5'd6;
        cy = 1'b1;
        r[4*i +: 4] = t[3:0];
      end else begin
        cy = 1'b0;
        r[4*i +: 4] = t[3:0];
      end
    end
    return {cy, r};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = go_bcd ? ADJ : HOLD;
      ADJ:     state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      IDLE:    in_ready_o  = 1'b1;
      HOLD:    out_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Binary result and flags for the op currently on the request lines.
  always_comb begin
    b_eff    = (bus.op == OP_SBC) ? ~bus.b : bus.b;
    sum      = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.carry_in};
    diff     = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    res_d    = bus.a;
    c_d      = bus.carry_in;
    v_d      = 1'b0;
    flag_src = '0;
    case (bus.op)
      OP_ADC, OP_SBC: begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: res_d = bus.a & bus.b;
      OP_ORA: res_d = bus.a | bus.b;
      OP_EOR: res_d = bus.a ^ bus.b;
      OP_ASL: begin
        res_d = {bus.a[WIDTH-2:0], 1'b0};
        c_d   = bus.a[WIDTH-1];
      end
      OP_LSR: begin
        res_d = {1'b0, bus.a[WIDTH-1:1]};
        c_d   = bus.a[0];
      end
      OP_ROL: begin
        res_d = {bus.a[WIDTH-2:0], bus.carry_in};
        c_d   = bus.a[WIDTH-1];
      end
      OP_ROR: begin
        res_d = {bus.carry_in, bus.a[WIDTH-1:1]};
        c_d   = bus.a[0];
      end
      OP_CMP: c_d = diff[WIDTH];
      default: ;
    endcase
    // compare reports N/Z of the difference while passing A through
    flag_src = (bus.op == OP_CMP) ? diff[WIDTH-1:0] : res_d;
    n_d      = flag_src[WIDTH-1];
    z_d      = (flag_src == '0);
  end

  assign bcd_out = bcd_adjust(a_q, b_q, c_q, sub_q);

  // Capture operands and binary N/V for the decimal adjust cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      bin_n_q <= 1'b0;
      bin_v_q <= 1'b0;
    end else if (accept && go_bcd) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      c_q     <= bus.carry_in;
      sub_q   <= (bus.op == OP_SBC);
      bin_n_q <= n_d;
      bin_v_q <= v_d;
    end
  end

  // Result/flag registers: loaded on a binary accept or at the end of ADJ,
  // otherwise held so they stay stable through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q_out <= 1'b0;
    end else if (accept && !go_bcd) begin
      res_q   <= res_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
      c_q_out <= c_d;
    end else if (state_q == ADJ) begin
      res_q   <= bcd_out[WIDTH-1:0];
      n_q     <= bin_n_q;
      v_q     <= bin_v_q;
      z_q     <= (bcd_out[WIDTH-1:0] == '0);
      c_q_out <= bcd_out[WIDTH];
    end
  end

  assign bus.in_ready  = in_ready_o;
  assign bus.out_valid = out_valid_o;
  assign bus.result    = res_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_v    = v_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_c    = c_q_out;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_6502_core.sv
// Directed bench for alu_6502_core: one decimal-capable instance and one
// binary-only instance share clock and reset.
module tb_alu_6502_core;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [1:0] st_d, st_b;

  alu_6502_if #(.WIDTH(8)) m ();
  alu_6502_if #(.WIDTH(8)) n ();

  alu_6502_core #(.WIDTH(8), .DECIMAL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(m), .dbg_state(st_d)
  );

  alu_6502_core #(.WIDTH(8), .DECIMAL_EN(1'b0)) dut_bin (
    .clk(clk), .rst_n(rst_n), .bus(n), .dbg_state(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // flags packed as {N,V,Z,C}
  function automatic logic [3:0] flags_m();
    return {m.flag_n, m.flag_v, m.flag_z, m.flag_c};
  endfunction

  function automatic logic [3:0] flags_n();
    return {n.flag_n, n.flag_v, n.flag_z, n.flag_c};
  endfunction

  // Present one request to the decimal instance; returns 1 ns after the
  // accepting edge.
  task automatic send(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic c, input logic d);
    m.op = o; m.a = av; m.b = bv; m.carry_in = c; m.decimal = d;
    m.in_valid = 1'b1;
    @(posedge clk); #1;
    m.in_valid = 1'b0;
  endtask

  // Expect out_valid to rise exactly lat edges after acceptance.
  task automatic expect_latency(input string tag, input int lat);
    for (int i = 1; i < lat; i++) begin
      check({tag, "_early"}, {31'd0, m.out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check({tag, "_valid"}, {31'd0, m.out_valid}, 32'd1);
  endtask

  task automatic consume(input string tag);
    m.out_ready = 1'b1;
    @(posedge clk); #1;
    m.out_ready = 1'b0;
    check({tag, "_idle"}, {31'd0, m.in_ready}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    m.in_valid = 1'b0; m.op = 4'd0; m.a = 8'h00; m.b = 8'h00;
    m.carry_in = 1'b0; m.decimal = 1'b0; m.out_ready = 1'b0;
    n.in_valid = 1'b0; n.op = 4'd0; n.a = 8'h00; n.b = 8'h00;
    n.carry_in = 1'b0; n.decimal = 1'b0; n.out_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, m.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, m.out_valid}, 32'd0);
    check("rst_result", {24'd0, m.result}, 32'h00);
    check("rst_flags", {28'd0, flags_m()}, 32'h0);
    check("rst_state", {30'd0, st_d}, 32'd0);
    check("rst_bin_out_valid", {31'd0, n.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADC 0x50+0x50: signed overflow
    send(4'd0, 8'h50, 8'h50, 1'b0, 1'b0);
    expect_latency("adc", 1);
    check("adc_result", {24'd0, m.result}, 32'hA0);
    check("adc_flags", {28'd0, flags_m()}, 32'hC);
    consume("adc");

    // SBC 0x00-0x01 with no incoming borrow
    send(4'd1, 8'h00, 8'h01, 1'b1, 1'b0);
    expect_latency("sbc", 1);
    check("sbc_result", {24'd0, m.result}, 32'hFF);
    check("sbc_flags", {28'd0, flags_m()}, 32'h8);
    consume("sbc");

    // BCD ADC 58+46+1 = 105
    send(4'd0, 8'h58, 8'h46, 1'b1, 1'b1);
    check("bcd_adc_adj_state", {30'd0, st_d}, 32'd1);
    check("bcd_adc_in_ready", {31'd0, m.in_ready}, 32'd0);
    expect_latency("bcd_adc", 2);
    check("bcd_adc_result", {24'd0, m.result}, 32'h05);
    check("bcd_adc_flags", {28'd0, flags_m()}, 32'hD);
    consume("bcd_adc");

    // same op on the binary-only instance: decimal ignored
    n.op = 4'd0; n.a = 8'h58; n.b = 8'h46; n.carry_in = 1'b1; n.decimal = 1'b1;
    n.in_valid = 1'b1;
    @(posedge clk); #1;
    n.in_valid = 1'b0;
    check("bin_adc_valid", {31'd0, n.out_valid}, 32'd1);
    check("bin_adc_result", {24'd0, n.result}, 32'h9F);
    check("bin_adc_flags", {28'd0, flags_n()}, 32'hC);
    n.out_ready = 1'b1;
    @(posedge clk); #1;
    n.out_ready = 1'b0;
    check("bin_adc_idle", {31'd0, n.in_ready}, 32'd1);

    // BCD SBC 10-01 = 09
    send(4'd1, 8'h10, 8'h01, 1'b1, 1'b1);
    expect_latency("bcd_sbc", 2);
    check("bcd_sbc_result", {24'd0, m.result}, 32'h09);
    check("bcd_sbc_flags", {28'd0, flags_m()}, 32'h1);
    consume("bcd_sbc");

    // CMP equal operands
    send(4'd9, 8'h40, 8'h40, 1'b0, 1'b0);
    expect_latency("cmp", 1);
    check("cmp_result", {24'd0, m.result}, 32'h40);
    check("cmp_flags", {28'd0, flags_m()}, 32'h3);
    consume("cmp");

    // ROR with carry in
    send(4'd8, 8'h01, 8'h00, 1'b1, 1'b0);
    expect_latency("ror", 1);
    check("ror_result", {24'd0, m.result}, 32'h80);
    check("ror_flags", {28'd0, flags_m()}, 32'h9);
    consume("ror");

    // ASL pushes msb into carry
    send(4'd5, 8'h81, 8'hFF, 1'b0, 1'b0);
    expect_latency("asl", 1);
    check("asl_result", {24'd0, m.result}, 32'h02);
    check("asl_flags", {28'd0, flags_m()}, 32'h1);
    consume("asl");

    // backpressure: AND held for 3 cycles, a stray request is ignored
    send(4'd2, 8'hF0, 8'h3C, 1'b1, 1'b0);
    expect_latency("and", 1);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        m.op = 4'd3; m.a = 8'h0F; m.b = 8'h00; m.carry_in = 1'b0;
        m.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      m.in_valid = 1'b0;
      check("bp_out_valid", {31'd0, m.out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, m.in_ready}, 32'd0);
      check("bp_result", {24'd0, m.result}, 32'h30);
      check("bp_flags", {28'd0, flags_m()}, 32'h1);
    end
    consume("bp");
    check("bp_released", {31'd0, m.out_valid}, 32'd0);

    // reset during the adjust cycle of a BCD op
    send(4'd0, 8'h19, 8'h28, 1'b0, 1'b1);
    check("mid_rst_in_adj", {30'd0, st_d}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, m.out_valid}, 32'd0);
    check("mid_rst_result", {24'd0, m.result}, 32'h00);
    check("mid_rst_flags", {28'd0, flags_m()}, 32'h0);
    check("mid_rst_in_ready", {31'd0, m.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'd0, 8'h01, 8'h01, 1'b0, 1'b0);
    expect_latency("post_rst", 1);
    check("post_rst_result", {24'd0, m.result}, 32'h02);
    check("post_rst_flags", {28'd0, flags_m()}, 32'h0);
    consume("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
